clk_switch_ctrl: RTL



---
 rtl/clk_net_pkg.sv | 17 +
 rtl/sync2.sv | 24 ++
 rtl/clk_switch_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/clk_net_pkg.sv
// Shared types for the clock-network control blocks.
package clk_net_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SETTLE = 3'd2,
        DONE   = 3'd3,
        FAIL   = 3'd4
    } sw_state_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } clk_src_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-mux select sequencer: verifies the target toggle is alive, moves sel,
// waits a settle interval, then reports done/err.
module clk_switch_ctrl
    import clk_net_pkg::*;
#(
    parameter int WIN_CYC    = 64,
    parameter int MIN_EDGES  = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic tgl0,
    input  logic tgl1,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int WW = $clog2(WIN_CYC + 1);
    localparam int EW = $clog2(MIN_EDGES + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    logic [1:0] w_tgl;
    logic [1:0] w_sync;
    logic [1:0] r_hist;
    logic [1:0] w_edge;

    assign w_tgl = {tgl1, tgl0};

    for (genvar g = 0; g < 2; g++) begin : g_sync
        sync2 u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .i_d   (w_tgl[g]),
            .o_q   (w_sync[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= 2'b00;
        else        r_hist <= w_sync;
    end

    assign w_edge = w_sync ^ r_hist;

    sw_state_t      r_state;
    clk_src_t       r_tgt;
    logic [WW-1:0]  r_win;
    logic [EW-1:0]  r_edges;
    logic [SW-1:0]  r_set;
    logic           r_sel;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic           w_tgt_edge;
    logic [EW-1:0]  w_edges_nxt;
    logic           w_win_last;
    logic           w_set_last;

    // Only the selected target's edges count; the count saturates so it never wraps.
    assign w_tgt_edge  = (r_tgt == SRC1) ? w_edge[1] : w_edge[0];
    assign w_edges_nxt = (w_tgt_edge && (r_edges != EW'(MIN_EDGES))) ? r_edges + EW'(1) : r_edges;
    assign w_win_last  = (r_win == WW'(WIN_CYC - 1));
    assign w_set_last  = (r_set == SW'(SETTLE_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tgt   <= SRC0;
            r_win   <= '0;
            r_edges <= '0;
            r_set   <= '0;
            r_sel   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_tgt   <= clk_src_t'(req_sel);
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (req_sel == r_sel) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_win   <= '0;
                            r_edges <= '0;
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    r_edges <= w_edges_nxt;
                    if (w_win_last) begin
                        if (w_edges_nxt >= EW'(MIN_EDGES)) begin
                            r_sel   <= r_tgt;
                            r_set   <= '0;
                            r_state <= SETTLE;
                        end else begin
                            r_state <= FAIL;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_win <= r_win + WW'(1);
                    end
                end
                SETTLE: begin
                    if (w_set_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_set <= r_set + SW'(1);
                    end
                end
                DONE, FAIL: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
